pw_trigger_monitor: RTL and testbench

PW_TRIGGER_MONITOR -- requirements
Module: pw_trigger_monitor

---
 rtl/pw_trigger_monitor.sv | 160 ++++++++++++++++
 tb/tb_pw_trigger_monitor.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pw_trigger_monitor.sv
// Purpose: measures match-to-trigger delay and trigger pulse width, with sticky error flags and an event counter.
// Latency: O_valid and the measurements update on the edge that samples I_trigger falling; all outputs are registered.
// Backpressure: a finished result is held in DONE until I_ack; match/trigger activity is ignored until then.
module pw_trigger_monitor #(
    parameter int pDELAY_WIDTH = 20,
    parameter int pWIDTH_WIDTH = 17,
    parameter int pCOUNT_WIDTH = 16
) (
    input  logic                    trigger_clk,
    input  logic                    reset_i,
    input  logic                    I_match,
    input  logic                    I_trigger,
    input  logic [pDELAY_WIDTH-1:0] I_timeout,
    input  logic                    I_ack,
    input  logic                    I_clear,
    output logic [pDELAY_WIDTH-1:0] O_measured_delay,
    output logic [pWIDTH_WIDTH-1:0] O_measured_width,
    output logic                    O_valid,
    output logic                    O_timeout,
    output logic                    O_orphan,
    output logic                    O_saturated,
    output logic [pCOUNT_WIDTH-1:0] O_trig_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HIGH = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic                    match_prev_q;
    logic                    match_armed_q;
    logic                    trig_prev_q;
    logic [pDELAY_WIDTH-1:0] delay_cnt_q, delay_cnt_d;
    logic [pWIDTH_WIDTH-1:0] width_cnt_q, width_cnt_d;

    logic [pDELAY_WIDTH-1:0] meas_delay_d;
    logic [pWIDTH_WIDTH-1:0] meas_width_d;
    logic                    valid_d;
    logic                    timeout_d;
    logic                    orphan_d;
    logic                    saturated_d;
    logic [pCOUNT_WIDTH-1:0] trig_count_d;

    logic                    match_edge;
    logic                    trig_rise;
    logic                    timeout_hit;

    // A match edge needs a low sample since reset, so a level held through reset is not an edge.
    assign match_edge  = I_match && !match_prev_q && match_armed_q;
    assign trig_rise   = I_trigger && !trig_prev_q;
    assign timeout_hit = (I_timeout != '0) && (delay_cnt_q == (I_timeout - pDELAY_WIDTH'(1)));

    // Next-state and next-output logic; I_clear is applied last so it overrides every transition.
    always_comb begin
        state_d      = state_q;
        delay_cnt_d  = delay_cnt_q;
        width_cnt_d  = width_cnt_q;
        meas_delay_d = O_measured_delay;
        meas_width_d = O_measured_width;
        valid_d      = O_valid;
        timeout_d    = O_timeout;
        orphan_d     = O_orphan;
        saturated_d  = O_saturated;
        trig_count_d = O_trig_count;

        case (state_q)
            ST_IDLE: begin
                if (match_edge) begin
                    state_d     = ST_WAIT;
                    delay_cnt_d = '0;
                end else if (trig_rise) begin
                    orphan_d = 1'b1;
                end
            end
            ST_WAIT: begin
                if (I_trigger) begin
                    state_d      = ST_HIGH;
                    meas_delay_d = delay_cnt_q;
                    width_cnt_d  = pWIDTH_WIDTH'(1);
                end else if (timeout_hit) begin
                    state_d   = ST_IDLE;
                    timeout_d = 1'b1;
                end else if (&delay_cnt_q) begin
                    saturated_d = 1'b1;
                end else begin
                    delay_cnt_d = delay_cnt_q + pDELAY_WIDTH'(1);
                end
            end
            ST_HIGH: begin
                if (I_trigger) begin
                    if (&width_cnt_q) begin
                        saturated_d = 1'b1;
                    end else begin
                        width_cnt_d = width_cnt_q + pWIDTH_WIDTH'(1);
                    end
                end else begin
                    state_d      = ST_DONE;
                    meas_width_d = width_cnt_q;
                    valid_d      = 1'b1;
                    if (!(&O_trig_count)) begin
                        trig_count_d = O_trig_count + pCOUNT_WIDTH'(1);
                    end
                end
            end
            ST_DONE: begin
                if (I_ack) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (I_clear) begin
            state_d      = ST_IDLE;
            valid_d      = 1'b0;
            timeout_d    = 1'b0;
            orphan_d     = 1'b0;
            saturated_d  = 1'b0;
            trig_count_d = '0;
        end
    end

    // State, counters, edge detectors and registered outputs.
    always_ff @(posedge trigger_clk or posedge reset_i) begin
        if (reset_i) begin
            state_q          <= ST_IDLE;
            match_prev_q     <= 1'b0;
            match_armed_q    <= 1'b0;
            trig_prev_q      <= 1'b0;
            delay_cnt_q      <= '0;
            width_cnt_q      <= '0;
            O_measured_delay <= '0;
            O_measured_width <= '0;
            O_valid          <= 1'b0;
            O_timeout        <= 1'b0;
            O_orphan         <= 1'b0;
            O_saturated      <= 1'b0;
            O_trig_count     <= '0;
        end else begin
            state_q          <= state_d;
            match_prev_q     <= I_match;
            match_armed_q    <= match_armed_q | ~I_match;
            trig_prev_q      <= I_trigger;
            delay_cnt_q      <= delay_cnt_d;
            width_cnt_q      <= width_cnt_d;
            O_measured_delay <= meas_delay_d;
            O_measured_width <= meas_width_d;
            O_valid          <= valid_d;
            O_timeout        <= timeout_d;
            O_orphan         <= orphan_d;
            O_saturated      <= saturated_d;
            O_trig_count     <= trig_count_d;
        end
    end

endmodule

// File: tb/tb_pw_trigger_monitor.sv
// Directed bench for pw_trigger_monitor, built with a 4-bit width field so width saturation is reachable.
module tb_pw_trigger_monitor;

    localparam int DW = 20;
    localparam int WW = 4;
    localparam int CW = 16;

    logic          trigger_clk = 1'b0;
    logic          reset_i;
    logic          I_match;
    logic          I_trigger;
    logic [DW-1:0] I_timeout;
    logic          I_ack;
    logic          I_clear;
    logic [DW-1:0] O_measured_delay;
    logic [WW-1:0] O_measured_width;
    logic          O_valid;
    logic          O_timeout;
    logic          O_orphan;
    logic          O_saturated;
    logic [CW-1:0] O_trig_count;

    int n_vec = 0;
    int n_bad = 0;

    pw_trigger_monitor #(
        .pDELAY_WIDTH(DW),
        .pWIDTH_WIDTH(WW),
        .pCOUNT_WIDTH(CW)
    ) dut (
        .trigger_clk      (trigger_clk),
        .reset_i          (reset_i),
        .I_match          (I_match),
        .I_trigger        (I_trigger),
        .I_timeout        (I_timeout),
        .I_ack            (I_ack),
        .I_clear          (I_clear),
        .O_measured_delay (O_measured_delay),
        .O_measured_width (O_measured_width),
        .O_valid          (O_valid),
        .O_timeout        (O_timeout),
        .O_orphan         (O_orphan),
        .O_saturated      (O_saturated),
        .O_trig_count     (O_trig_count)
    );

    always #5 trigger_clk = ~trigger_clk;

    // Advance one rising edge; outputs are then sampled and inputs changed 1ns later.
    task automatic step();
        @(posedge trigger_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        reset_i   = 1'b1;
        I_match   = 1'b0;
        I_trigger = 1'b0;
        I_timeout = '0;
        I_ack     = 1'b0;
        I_clear   = 1'b0;
        step();
        step();
        chk("rst_valid", 32'(O_valid), 0);
        chk("rst_count", 32'(O_trig_count), 0);
        chk("rst_flags", {29'd0, O_timeout, O_orphan, O_saturated}, 0);
        reset_i = 1'b0;
        step();

        // Basic measurement: match edge at E0, trigger sampled high at E5..E7.
        I_match = 1'b1;
        step();
        I_match = 1'b0;
        repeat (4) step();
        I_trigger = 1'b1;
        step();
        step();
        step();
        chk("basic_valid_before_fall", 32'(O_valid), 0);
        I_trigger = 1'b0;
        step();
        chk("basic_valid", 32'(O_valid), 1);
        chk("basic_delay", 32'(O_measured_delay), 4);
        chk("basic_width", 32'(O_measured_width), 3);
        chk("basic_count", 32'(O_trig_count), 1);
        I_ack = 1'b1;
        step();
        I_ack = 1'b0;
        chk("ack_valid", 32'(O_valid), 0);
        chk("ack_delay_held", 32'(O_measured_delay), 4);

        // Timeout of 10 cycles with no trigger.
        I_timeout = DW'(10);
        I_match   = 1'b1;
        step();
        I_match = 1'b0;
        repeat (9) step();
        chk("timeout_early", 32'(O_timeout), 0);
        step();
        chk("timeout_set", 32'(O_timeout), 1);
        chk("timeout_valid", 32'(O_valid), 0);
        chk("timeout_delay_kept", 32'(O_measured_delay), 4);
        I_timeout = '0;

        // Orphan pulse in IDLE, then a measurement with delay 0 and width 1.
        I_trigger = 1'b1;
        step();
        I_trigger = 1'b0;
        chk("orphan_set", 32'(O_orphan), 1);
        step();
        I_match = 1'b1;
        step();
        I_match   = 1'b0;
        I_trigger = 1'b1;
        step();
        I_trigger = 1'b0;
        step();
        chk("min_valid", 32'(O_valid), 1);
        chk("min_delay", 32'(O_measured_delay), 0);
        chk("min_width", 32'(O_measured_width), 1);
        chk("min_count", 32'(O_trig_count), 2);

        // Activity during DONE without ack is ignored.
        I_match   = 1'b1;
        I_trigger = 1'b1;
        step();
        I_match = 1'b0;
        step();
        I_match = 1'b1;
        step();
        I_match   = 1'b0;
        I_trigger = 1'b0;
        step();
        chk("done_hold_delay", 32'(O_measured_delay), 0);
        chk("done_hold_width", 32'(O_measured_width), 1);
        chk("done_hold_count", 32'(O_trig_count), 2);
        chk("done_hold_valid", 32'(O_valid), 1);
        I_ack = 1'b1;
        step();
        I_ack = 1'b1;
        step();
        I_ack = 1'b0;
        chk("ack_idle_no_effect", 32'(O_trig_count), 2);

        // Clear of sticky flags and counter.
        I_clear = 1'b1;
        step();
        I_clear = 1'b0;
        chk("clear_flags", {29'd0, O_timeout, O_orphan, O_saturated}, 0);
        chk("clear_count", 32'(O_trig_count), 0);

        // Match and trigger in the same IDLE cycle.
        I_match   = 1'b1;
        I_trigger = 1'b1;
        step();
        I_match = 1'b0;
        step();
        I_trigger = 1'b0;
        step();
        chk("same_orphan", 32'(O_orphan), 0);
        chk("same_valid", 32'(O_valid), 1);
        chk("same_delay", 32'(O_measured_delay), 0);
        chk("same_width", 32'(O_measured_width), 1);
        chk("same_count", 32'(O_trig_count), 1);

        // Ack and clear together in DONE: clear wins, back to IDLE.
        I_ack   = 1'b1;
        I_clear = 1'b1;
        step();
        I_ack   = 1'b0;
        I_clear = 1'b0;
        chk("ackclr_valid", 32'(O_valid), 0);
        chk("ackclr_count", 32'(O_trig_count), 0);
        I_trigger = 1'b1;
        step();
        I_trigger = 1'b0;
        chk("ackclr_idle_orphan", 32'(O_orphan), 1);
        I_clear = 1'b1;
        step();
        I_clear = 1'b0;

        // Width saturation: trigger held 20 cycles against a 4-bit width.
        I_match = 1'b1;
        step();
        I_match   = 1'b0;
        I_trigger = 1'b1;
        repeat (20) step();
        I_trigger = 1'b0;
        step();
        chk("sat_width", 32'(O_measured_width), 15);
        chk("sat_flag", 32'(O_saturated), 1);
        chk("sat_count", 32'(O_trig_count), 1);
        I_ack = 1'b1;
        step();
        I_ack = 1'b0;

        // Asynchronous reset while in HIGH.
        I_match = 1'b1;
        step();
        I_match   = 1'b0;
        I_trigger = 1'b1;
        step();
        step();
        reset_i = 1'b1;
        #1;
        chk("arst_width", 32'(O_measured_width), 0);
        chk("arst_count", 32'(O_trig_count), 0);
        chk("arst_flags", {28'd0, O_valid, O_timeout, O_orphan, O_saturated}, 0);
        I_trigger = 1'b0;
        I_match   = 1'b1;
        step();
        reset_i = 1'b0;

        // Match held high across reset is not an edge: a trigger pulse is still an orphan.
        step();
        step();
        I_trigger = 1'b1;
        step();
        I_trigger = 1'b0;
        chk("held_match_no_edge", 32'(O_orphan), 1);
        I_match = 1'b0;
        step();
        I_match = 1'b1;
        step();
        I_match   = 1'b0;
        I_trigger = 1'b1;
        step();
        I_trigger = 1'b0;
        step();
        chk("post_rst_valid", 32'(O_valid), 1);
        chk("post_rst_delay", 32'(O_measured_delay), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
